// File: rtl/dsp_ctrl_pkg.sv
// Shared types and DSP opmode constants for the MAC sequencer.
// Tags are all-zero when no operand occupies the slot.
package dsp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  localparam logic [7:0] OPM_FIRST   = 8'h01;
  localparam logic [7:0] OPM_FIRST_C = 8'h0D;
  localparam logic [7:0] OPM_ACC     = 8'h09;
  localparam logic [7:0] OPM_HOLD    = 8'h08;

  localparam int PIPE_D = 3;

  typedef struct packed {
    logic valid;
    logic first;
  } tag_t;

  function automatic logic [7:0] stage1_opmode(
    input tag_t t,
    input logic usec
  );
    if (!t.valid) return OPM_HOLD;
    if (t.first) return usec ? OPM_FIRST_C : OPM_FIRST;
    return OPM_ACC;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_vld_pipe.sv
// Three-deep valid/first tag shift register mirroring the DSP pipeline.
// stage[0] is one cycle after acceptance, stage[2] lines up with P.
module dsp_vld_pipe
  import dsp_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  tag_t              tag,
  output tag_t [PIPE_D-1:0] stage
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage <= '0;
    end else if (flush) begin
      stage <= '0;
    end else begin
      stage <= {stage[PIPE_D-2:0], tag};
    end
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams operand pairs into a registered DSP MAC slice and
// returns the accumulated 48-bit dot product.
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_usec,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [47:0]       res_data,
  output logic              res_err,
  input  logic              abort,
  output logic [DATA_W-1:0] dsp_a,
  output logic [DATA_W-1:0] dsp_b,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_cea,
  output logic              dsp_ceb,
  output logic              dsp_cem,
  output logic              dsp_cep,
  output logic              dsp_ceopmode,
  input  logic [47:0]       dsp_p
);

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic              usec;
  logic              ce;
  logic              accept;
  logic              last;
  logic              flush;
  logic              drain_done;
  tag_t              tag;
  tag_t [PIPE_D-1:0] stage;

  assign accept = op_valid && op_ready;
  assign last   = accept && (cnt == len - LEN_W'(1));
  assign flush  = abort && (state == LOAD || state == DRAIN);

  assign tag.valid = accept;
  assign tag.first = accept && (cnt == '0);

  // Newest tag has reached the P stage with nothing behind it.
  assign drain_done = (stage[2] != '0) && (stage[1:0] == '0);

  dsp_vld_pipe u_pipe (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .tag   (tag),
    .stage (stage)
  );

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    ce        = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = (cmd_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        op_ready = 1'b1;
        ce       = 1'b1;
        if (abort) state_nxt = IDLE;
        else if (last) state_nxt = DRAIN;
      end
      DRAIN: begin
        ce = 1'b1;
        if (abort) state_nxt = IDLE;
        else if (drain_done) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      len      <= '0;
      cnt      <= '0;
      usec     <= 1'b0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        len      <= cmd_len;
        usec     <= cmd_usec;
        cnt      <= '0;
        res_data <= '0;
        res_err  <= (cmd_len == '0);
      end
      if (accept) cnt <= cnt + LEN_W'(1);
      if (state == DRAIN && !abort && drain_done) begin
        res_data <= dsp_p;
      end
    end
  end

  assign dsp_a        = op_ready ? op_a : '0;
  assign dsp_b        = op_ready ? op_b : '0;
  assign dsp_opmode   = stage1_opmode(stage[0], usec);
  assign dsp_cea      = ce;
  assign dsp_ceb      = ce;
  assign dsp_cem      = ce;
  assign dsp_cep      = ce;
  assign dsp_ceopmode = ce;

endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of dot-product length field.
REQ-002 SHALL have parameter DATA_W, default 18, operand width matching DSP A/B ports.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock for all state.
REQ-004 SHALL have rstn input 1, asynchronous active-low reset.
REQ-005 SHALL have: cmd_valid input 1; cmd_ready output 1; cmd_len input LEN_W (products to sum); cmd_usec input 1 (seed accumulator from DSP C port).
REQ-006 SHALL have: op_valid input 1; op_ready output 1; op_a input DATA_W; op_b input DATA_W.
REQ-007 SHALL have: res_valid output 1; res_ready input 1; res_data output 48; res_err output 1 (cmd_len was zero).
REQ-008 SHALL have: abort input 1, synchronous cancel of the current command.
REQ-009 SHALL have DSP-side ports: dsp_a output DATA_W; dsp_b output DATA_W; dsp_opmode output 8; dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode outputs 1 each; dsp_p input 48.

Function
REQ-010 SHALL target a DSP configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT "DIRECT".
REQ-011 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, latch cmd_len and cmd_usec; go to LOAD if cmd_len!=0, else DONE with res_data=0 and res_err=1.
REQ-013 LOAD: op_ready=1; an operand is accepted on op_valid&op_ready; accepted count increments; after the cmd_len-th acceptance go to DRAIN.
REQ-014 dsp_a/dsp_b SHALL equal op_a/op_b while op_ready=1, else 0.
REQ-015 dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode SHALL be 1 in LOAD and DRAIN, 0 in IDLE and DONE.
REQ-016 A 3-stage valid/first tag pipeline SHALL track each accepted operand; stage 1 (one cycle after acceptance) selects dsp_opmode.
REQ-017 dsp_opmode at stage 1: first product 8'h01 (X=M, Z=0), or 8'h0D (X=M, Z=C) if cmd_usec; later products 8'h09 (X=M, Z=P); bubble 8'h08 (X=0, Z=P, hold); IDLE/DONE 8'h08.
REQ-018 An op_valid gap SHALL insert a bubble and never corrupt the sum.
REQ-019 Latency: the last operand accepted in cycle t produces its sum on dsp_p in cycle t+3; DRAIN SHALL last until the tag pipeline is empty, then capture dsp_p into res_data and enter DONE.
REQ-020 DONE: res_valid=1, res_data and res_err stable; on res_ready go to IDLE the same edge.
REQ-021 cmd_ready SHALL be 0 outside IDLE; a new command SHALL NOT be accepted in the cycle DONE completes.
REQ-022 abort in LOAD or DRAIN SHALL return to IDLE next edge, flush the tag pipeline, and produce no result; abort in IDLE or DONE SHALL be ignored.
REQ-023 res_data is the 48-bit wrap-around DSP sum; no saturation or overflow flag.

Reset
REQ-024 rstn low SHALL asynchronously force IDLE, counter=0, tag pipeline empty, res_data=0, res_valid=0, res_err=0, all CE outputs 0, dsp_opmode=8'h08, dsp_a=dsp_b=0.
REQ-025 Reset mid-command SHALL discard the command; the first command after reset SHALL seed with opmode 8'h01 or 8'h0D regardless of the DSP P content.

Structure
REQ-026 A shared package dsp_ctrl_pkg SHALL hold the state enum and opmode constants OPM_FIRST=8'h01, OPM_FIRST_C=8'h0D, OPM_ACC=8'h09, OPM_HOLD=8'h08.
REQ-027 The tag pipeline SHALL be sub-module dsp_vld_pipe (depth 3, valid+first bits, synchronous flush).

Verification
REQ-028 With the DSP model attached, len=4, a={1,2,3,4}, b={5,6,7,8} back-to-back -> res_data=70 three cycles after the last accept, res_err=0.
REQ-029 len=3, a={-2,3,1}, b={4,4,-7}, op_valid gaps of 2 cycles -> res_data=48'hFFFF_FFFF_FFFD (-3).
REQ-030 cmd_usec=1, C=100, len=2, a={10,1}, b={10,1} -> res_data=201.
REQ-031 len=0 -> DONE next cycle, res_data=0, res_err=1, no CE pulses.
REQ-032 abort after 2 of 5 operands, then len=1 a=3 b=3 -> res_data=9; rstn pulse mid-LOAD -> all outputs at reset values immediately.
REQ-033 res_ready held low 10 cycles -> res_valid and res_data stable, cmd_ready=0 throughout.
